// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: Avalon-MM registers program half-period and length in samples, and the output is a continuous sample stream.
// A start or stop changes sample_data one clock after the write; while sample_ready is low the current sample and all counters hold.
module sfx_tone_gen #(
  parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
  parameter int                 SAMPLE_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic [1:0]                 address,
  input  logic [15:0]                writedata,
  output logic [15:0]                readdata,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic                       sample_valid,
  input  logic                       sample_ready
);

  localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
  localparam logic signed [SAMPLE_W-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [15:0] half_period;
  logic [15:0] duration;
  logic [15:0] hp_s, hp_nxt;
  logic [15:0] remain, remain_nxt;
  logic [15:0] phase, phase_nxt;
  logic        sign_neg, sign_neg_nxt;
  logic signed [SAMPLE_W-1:0] data_nxt;

  logic reg_wr;
  logic start;
  logic stop;
  logic accept;
  logic busy;

  assign reg_wr = chipselect && write;
  assign start  = reg_wr && (address == 2'd2) && writedata[0];
  assign stop   = reg_wr && (address == 2'd2) && writedata[1];
  assign accept = sample_valid && sample_ready;
  assign busy   = (state == PLAY);

  // Programming registers only take effect when a tone is started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_period <= 16'd0;
      duration    <= 16'd0;
    end else if (reg_wr) begin
      if (address == 2'd0) half_period <= writedata;
      if (address == 2'd1) duration    <= writedata;
    end
  end

  always_comb begin
    readdata = 16'd0;
    case (address)
      2'd0:    readdata = half_period;
      2'd1:    readdata = duration;
      2'd2:    readdata = 16'd0;
      default: readdata = {15'd0, busy};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stop outranks start, and start outranks sample acceptance.
  always_comb begin
    state_nxt    = state;
    hp_nxt       = hp_s;
    remain_nxt   = remain;
    phase_nxt    = phase;
    sign_neg_nxt = sign_neg;
    data_nxt     = sample_data;

    if (stop) begin
      state_nxt    = IDLE;
      remain_nxt   = 16'd0;
      phase_nxt    = 16'd0;
      sign_neg_nxt = 1'b0;
      data_nxt     = '0;
    end else if (start && (duration != 16'd0)) begin
      state_nxt    = PLAY;
      hp_nxt       = (half_period == 16'd0) ? 16'd1 : half_period;
      remain_nxt   = duration;
      phase_nxt    = 16'd0;
      sign_neg_nxt = 1'b0;
      data_nxt     = AMP_POS;
    end else if ((state == PLAY) && accept) begin
      remain_nxt = remain - 16'd1;
      if (remain == 16'd1) begin
        state_nxt    = IDLE;
        phase_nxt    = 16'd0;
        sign_neg_nxt = 1'b0;
        data_nxt     = '0;
      end else begin
        if (phase == hp_s - 16'd1) begin
          phase_nxt    = 16'd0;
          sign_neg_nxt = ~sign_neg;
        end else begin
          phase_nxt = phase + 16'd1;
        end
        data_nxt = sign_neg_nxt ? AMP_NEG : AMP_POS;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_s         <= 16'd0;
      remain       <= 16'd0;
      phase        <= 16'd0;
      sign_neg     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      hp_s         <= hp_nxt;
      remain       <= remain_nxt;
      phase        <= phase_nxt;
      sign_neg     <= sign_neg_nxt;
      sample_data  <= data_nxt;
      sample_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Directed bench for sfx_tone_gen: register access, tone sequences, backpressure, start/stop and async reset.
module tb_sfx_tone_gen;

  localparam logic [15:0] PA = 16'h2000;
  localparam logic [15:0] NA = 16'hE000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               chipselect = 1'b0;
  logic               write = 1'b0;
  logic [1:0]         address = 2'd3;
  logic [15:0]        writedata = 16'd0;
  logic [15:0]        readdata;
  logic signed [15:0] sample_data;
  logic               sample_valid;
  logic               sample_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] seq8  [8]  = '{PA, PA, NA, NA, PA, PA, NA, NA};
  logic [15:0] seq6  [6]  = '{PA, PA, PA, NA, NA, NA};
  logic [15:0] seq4  [4]  = '{PA, NA, PA, NA};
  logic [15:0] seq10 [10] = '{PA, PA, PA, PA, PA, NA, NA, NA, NA, NA};

  sfx_tone_gen dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write is taken.
  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    address    = 2'd3;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
    address = 2'd3;
  endtask

  initial begin
    #5;
    chk("rst_valid", {15'd0, sample_valid}, 16'd0);
    chk("rst_data", sample_data, 16'd0);
    rd("rst_hp", 2'd0, 16'd0);
    rd("rst_dur", 2'd1, 16'd0);
    rd("rst_busy", 2'd3, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {15'd0, sample_valid}, 16'd1);
    chk("idle_data", sample_data, 16'd0);

    // Tone 1: HP=2, DUR=8, sink always ready
    sample_ready = 1'b1;
    bus_wr(2'd0, 16'd2);
    bus_wr(2'd1, 16'd8);
    rd("t1_hp", 2'd0, 16'd2);
    rd("t1_dur", 2'd1, 16'd8);
    chk("t1_idle_data", sample_data, 16'd0);
    bus_wr(2'd2, 16'd1);
    rd("t1_ctrl_rd", 2'd2, 16'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_s%0d", i), sample_data, seq8[i]);
      if (i == 7) rd("t1_busy_last", 2'd3, 16'd1);
      @(negedge clk);
    end
    chk("t1_end_data", sample_data, 16'd0);
    rd("t1_end_busy", 2'd3, 16'd0);

    // Tone 2: HP=3, DUR=6, ready toggling
    sample_ready = 1'b0;
    bus_wr(2'd0, 16'd3);
    bus_wr(2'd1, 16'd6);
    bus_wr(2'd2, 16'd1);
    for (int i = 0; i < 6; i++) begin
      sample_ready = 1'b0;
      chk($sformatf("t2_s%0d", i), sample_data, seq6[i]);
      @(negedge clk);
      chk($sformatf("t2_hold%0d", i), sample_data, seq6[i]);
      sample_ready = 1'b1;
      @(negedge clk);
    end
    chk("t2_end_data", sample_data, 16'd0);
    rd("t2_end_busy", 2'd3, 16'd0);

    // Tone 3: HP=0 behaves as HP=1
    bus_wr(2'd0, 16'd0);
    bus_wr(2'd1, 16'd4);
    bus_wr(2'd2, 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_s%0d", i), sample_data, seq4[i]);
      @(negedge clk);
    end
    chk("t3_end_data", sample_data, 16'd0);

    // DUR=0 start is ignored
    bus_wr(2'd1, 16'd0);
    bus_wr(2'd2, 16'd1);
    rd("t4_busy", 2'd3, 16'd0);
    chk("t4_data", sample_data, 16'd0);
    @(negedge clk);
    chk("t4_data_later", sample_data, 16'd0);

    // Mid-tone HP write, then start+stop together
    sample_ready = 1'b0;
    bus_wr(2'd0, 16'd2);
    bus_wr(2'd1, 16'd10);
    bus_wr(2'd2, 16'd1);
    chk("t5_first", sample_data, PA);
    bus_wr(2'd0, 16'd5);
    rd("t5_hp_rd", 2'd0, 16'd5);
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_s%0d", i), sample_data, seq8[i]);
      @(negedge clk);
    end
    sample_ready = 1'b0;
    rd("t5_busy_pre", 2'd3, 16'd1);
    bus_wr(2'd2, 16'd3);
    chk("t5_stop_data", sample_data, 16'd0);
    rd("t5_stop_busy", 2'd3, 16'd0);
    sample_ready = 1'b1;
    bus_wr(2'd2, 16'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_hp5_s%0d", i), sample_data, seq10[i]);
      @(negedge clk);
    end
    chk("t5_end_data", sample_data, 16'd0);

    // Asynchronous reset in the middle of a tone
    bus_wr(2'd2, 16'd1);
    @(negedge clk);
    chk("t6_playing", sample_data, PA);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {15'd0, sample_valid}, 16'd0);
    chk("t6_rst_data", sample_data, 16'd0);
    rd("t6_rst_busy", 2'd3, 16'd0);
    rd("t6_rst_dur", 2'd1, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rel_valid", {15'd0, sample_valid}, 16'd1);
    chk("t6_rel_data", sample_data, 16'd0);
    rd("t6_rel_busy", 2'd3, 16'd0);
    bus_wr(2'd2, 16'd1);
    rd("t6_nodur_busy", 2'd3, 16'd0);
    chk("t6_nodur_data", sample_data, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_tone_gen.md
SFX_TONE_GEN -- requirements
Module: sfx_tone_gen

Interface
Parameters:
REQ-001 SHALL declare AMPLITUDE, default 16'sd8192, signed magnitude of the square wave.
REQ-002 SHALL declare SAMPLE_W, default 16, width of the sample bus.
Ports:
REQ-003 SHALL declare `clk`, input, 1, the only clock (50 MHz).
REQ-004 SHALL declare `reset`, input, 1, asynchronous, active-high.
REQ-005 SHALL declare `chipselect`, input, 1, Avalon-MM slave select.
REQ-006 SHALL declare `write`, input, 1, Avalon-MM write strobe.
REQ-007 SHALL declare `address`, input, 2, register index.
REQ-008 SHALL declare `writedata`, input, 16, register write data.
REQ-009 SHALL declare `readdata`, output, 16, register read data.
REQ-010 SHALL declare `sample_data`, output, SAMPLE_W, signed sample toward the audio codec streaming sink.
REQ-011 SHALL declare `sample_valid`, output, 1, sample present.
REQ-012 SHALL declare `sample_ready`, input, 1, sink accepts the sample this cycle.

Function
REQ-013 SHALL accept a write only in a cycle where chipselect && write.
REQ-014 SHALL map addr 0 to HALF_PERIOD[15:0], in samples.
REQ-015 SHALL map addr 1 to DURATION[15:0], in samples.
REQ-016 SHALL map addr 2 to CTRL: bit0 = start, bit1 = stop; both are self-clearing pulses and are not stored.
REQ-017 SHALL map addr 3 to STATUS: read-only, writes ignored.
REQ-018 SHALL drive readdata combinationally: addr0 HALF_PERIOD, addr1 DURATION, addr2 0, addr3 {15'b0, busy}.
REQ-019 SHALL set busy = 1 exactly when the state is PLAY.
REQ-020 SHALL implement two states, IDLE and PLAY.
REQ-021 SHALL count a sample as accepted on a cycle where sample_valid && sample_ready.
REQ-022 SHALL hold sample_data stable until that sample is accepted; a new value appears on the cycle after acceptance.
REQ-023 SHALL drive sample_valid = 1 in every cycle after reset deasserts, in both states, because the codec needs a continuous stream.
REQ-024 SHALL output sample_data = 0 in IDLE.
REQ-025 SHALL, on start in IDLE with DURATION != 0, enter PLAY next cycle and latch hp_s = max(HALF_PERIOD,1) and dur_s = DURATION.
REQ-026 SHALL, on that entry, clear phase to 0, set sign to positive and set sample_data = +AMPLITUDE.
REQ-027 SHALL ignore start when DURATION == 0; the block stays in IDLE.
REQ-028 SHALL, for each accepted sample in PLAY, decrement the remaining count.
REQ-029 SHALL, for each accepted sample in PLAY, advance phase; when phase == hp_s-1, phase wraps to 0 and sign toggles.
REQ-030 SHALL drive the next sample as +AMPLITUDE or -AMPLITUDE per sign.
REQ-031 SHALL, when the last of dur_s samples is accepted, return to IDLE and make the next sample_data 0.
REQ-032 SHALL emit exactly dur_s nonzero samples per tone.
REQ-033 SHALL, on start during PLAY, restart: relatch both registers, phase 0, sign positive, next sample +AMPLITUDE.
REQ-034 SHALL, on stop in any state, go to IDLE next cycle with sample_data 0.
REQ-035 SHALL let stop win when start and stop are set in the same write.
REQ-036 SHALL not let writes to HALF_PERIOD or DURATION during PLAY affect the current tone; they apply at the next start.
REQ-037 SHALL freeze counters while sample_ready = 0; no sample is skipped or duplicated.
REQ-038 SHALL give a start a response latency of 1 clock from the write cycle to the changed sample_data.

Reset
REQ-039 SHALL, while reset = 1, drive: state IDLE, HALF_PERIOD 0, DURATION 0, phase 0, remaining count 0, sign positive, sample_data 0, sample_valid 0.
REQ-040 SHALL, on reset asserted mid-tone, abort immediately (asynchronously) to the REQ-039 values; no tone resumes after release.

Verification
REQ-041 SHALL cover: write HP=2, DUR=8, start, ready always 1 -> samples +A,+A,-A,-A,+A,+A,-A,-A then 0; busy drops after the 8th accept.
REQ-042 SHALL cover: HP=3, DUR=6, ready toggling 1/0 -> same 6-sample sequence +A,+A,+A,-A,-A,-A, data stable during ready=0, none lost.
REQ-043 SHALL cover: HP=0, DUR=4 -> treated as HP=1: +A,-A,+A,-A.
REQ-044 SHALL cover: DUR=0 start -> busy stays 0, data 0.
REQ-045 SHALL cover: mid-tone write HP=5 then CTRL=3 (start+stop) -> IDLE next cycle, data 0; a later start uses HP=5.
REQ-046 SHALL cover: reset pulse during PLAY (asynchronous, between clock edges) -> valid 0, data 0 immediately; after release valid=1, data 0, busy 0.
